// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for the shared memory port: IF requester, MEM requester and the
// downstream 64-bit bus. The arbiter takes the master view; requesters plus the
// memory slave take the slave view.
interface mem_port_arbiter_if;
  // IF requester
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  // MEM requester
  logic        mem_req;
  logic        mem_wen;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_wmask;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  // Memory bus
  logic        bus_valid;
  logic        bus_wen;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [63:0] bus_wmask;
  logic        bus_ready;
  logic [63:0] bus_rdata;

  modport master (
    input  if_req, if_addr,
    input  mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  bus_ready, bus_rdata,
    output if_ready, if_rdata,
    output mem_ready, mem_rdata,
    output bus_valid, bus_wen, bus_addr, bus_wdata, bus_wmask
  );

  modport slave (
    output if_req, if_addr,
    output mem_req, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output bus_ready, bus_rdata,
    input  if_ready, if_rdata,
    input  mem_ready, mem_rdata,
    input  bus_valid, bus_wen, bus_addr, bus_wdata, bus_wmask
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM requests onto one 64-bit memory port. MEM has priority,
// but IF is granted after at most MAX_MEM_RUN consecutive MEM grants while it waits.
// All outputs are registered; ready pulses last exactly one cycle.
module mem_port_arbiter #(
  parameter int unsigned MAX_MEM_RUN = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.master port
);

  localparam logic [3:0] MaxRun = 4'(MAX_MEM_RUN);
  localparam logic [63:0] DwordMask = ~64'h7;

  typedef enum logic [2:0] {
    StIdle,
    StBusyIf,
    StBusyMem,
    StDoneIf,
    StDoneMem
  } state_e;

  state_e     state;
  logic [3:0] run_cnt;
  logic       lane;
  logic       grant_mem;
  logic       grant_if;

  // Arbitration decision, only acted on in StIdle
  always_comb begin
    grant_mem = port.mem_req && !(port.if_req && (run_cnt == MaxRun));
    grant_if  = port.if_req && !grant_mem;
  end

  // Transaction FSM with registered bus and requester-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= StIdle;
      run_cnt        <= '0;
      lane           <= 1'b0;
      port.bus_valid <= 1'b0;
      port.bus_wen   <= 1'b0;
      port.bus_addr  <= '0;
      port.bus_wdata <= '0;
      port.bus_wmask <= '0;
      port.if_ready  <= 1'b0;
      port.if_rdata  <= '0;
      port.mem_ready <= 1'b0;
      port.mem_rdata <= '0;
    end else begin
      port.if_ready  <= 1'b0;
      port.mem_ready <= 1'b0;
      case (state)
        StIdle: begin
          if (grant_mem) begin
            port.bus_valid <= 1'b1;
            port.bus_wen   <= port.mem_wen;
            port.bus_addr  <= port.mem_addr & DwordMask;
            port.bus_wdata <= port.mem_wdata;
            port.bus_wmask <= port.mem_wmask;
            // if_req here implies run_cnt < MaxRun, so no overflow past the cap
            run_cnt        <= port.if_req ? run_cnt + 4'd1 : '0;
            state          <= StBusyMem;
          end else if (grant_if) begin
            port.bus_valid <= 1'b1;
            port.bus_wen   <= 1'b0;
            port.bus_addr  <= port.if_addr & DwordMask;
            port.bus_wdata <= '0;
            port.bus_wmask <= '0;
            lane           <= port.if_addr[2];
            run_cnt        <= '0;
            state          <= StBusyIf;
          end else begin
            run_cnt <= '0;
          end
        end
        StBusyIf: begin
          if (port.bus_ready) begin
            port.bus_valid <= 1'b0;
            port.if_ready  <= 1'b1;
            port.if_rdata  <= lane ? port.bus_rdata[63:32] : port.bus_rdata[31:0];
            state          <= StDoneIf;
          end
        end
        StBusyMem: begin
          if (port.bus_ready) begin
            port.bus_valid <= 1'b0;
            port.mem_ready <= 1'b1;
            port.mem_rdata <= port.bus_rdata;
            state          <= StDoneMem;
          end
        end
        StDoneIf, StDoneMem: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, with a
// transaction-level reference model compared against the DUT every cycle.
module tb_mem_port_arbiter;
  localparam int unsigned MaxRun = 4;
  localparam logic [63:0] IfA  = 64'h1000;
  localparam logic [63:0] MemA = 64'h2000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_port_arbiter_if p ();

  mem_port_arbiter #(.MAX_MEM_RUN(MaxRun)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (p.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: tracks the one outstanding transaction and the MEM run length
  bit          m_busy = 0;
  bit          m_done = 0;
  bit          m_who = 0;  // 0 = IF, 1 = MEM
  bit          m_lane = 0;
  int unsigned m_run = 0;
  logic        e_valid = 0, e_wen = 0, e_if_ready = 0, e_mem_ready = 0;
  logic [63:0] e_addr = 0, e_wdata = 0, e_wmask = 0, e_mem_rdata = 0;
  logic [31:0] e_if_rdata = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_done <= 0; m_who <= 0; m_lane <= 0; m_run <= 0;
      e_valid <= 0; e_wen <= 0; e_addr <= 0; e_wdata <= 0; e_wmask <= 0;
      e_if_ready <= 0; e_mem_ready <= 0; e_if_rdata <= 0; e_mem_rdata <= 0;
    end else begin
      e_if_ready  <= 0;
      e_mem_ready <= 0;
      if (m_busy) begin
        if (p.bus_ready) begin
          m_busy  <= 0;
          m_done  <= 1;
          e_valid <= 0;
          if (m_who) begin
            e_mem_ready <= 1;
            e_mem_rdata <= p.bus_rdata;
          end else begin
            e_if_ready <= 1;
            e_if_rdata <= 32'(m_lane ? (p.bus_rdata >> 32) : p.bus_rdata);
          end
        end
      end else if (m_done) begin
        m_done <= 0;
      end else if (p.if_req && (!p.mem_req || m_run >= MaxRun)) begin
        m_busy <= 1; m_who <= 0; m_run <= 0;
        m_lane <= p.if_addr[2];
        e_valid <= 1; e_wen <= 0; e_wdata <= 0; e_wmask <= 0;
        e_addr <= p.if_addr - (p.if_addr % 8);
      end else if (p.mem_req) begin
        m_busy <= 1; m_who <= 1;
        m_run <= p.if_req ? ((m_run + 1 > MaxRun) ? MaxRun : m_run + 1) : 0;
        e_valid <= 1; e_wen <= p.mem_wen; e_wdata <= p.mem_wdata; e_wmask <= p.mem_wmask;
        e_addr <= p.mem_addr - (p.mem_addr % 8);
      end else begin
        m_run <= 0;
      end
    end
  end

  // Per-cycle comparison against the model
  bit cmp_en = 0;
  always @(posedge clk) begin
    #1;
    if (!rst && cmp_en) begin
      check("bus_valid", p.bus_valid, e_valid);
      check("bus_wen", p.bus_wen, e_wen);
      check("bus_addr", p.bus_addr, e_addr);
      check("bus_wdata", p.bus_wdata, e_wdata);
      check("bus_wmask", p.bus_wmask, e_wmask);
      check("if_ready", p.if_ready, e_if_ready);
      check("mem_ready", p.mem_ready, e_mem_ready);
      check("if_rdata", p.if_rdata, e_if_rdata);
      check("mem_rdata", p.mem_rdata, e_mem_rdata);
    end
  end

  // Grant log from the DUT bus: one letter per new transaction, plus its cycle
  string glog = "";
  int    gcyc[$];
  int    cyc = 0;
  logic  prev_valid = 0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (p.bus_valid && !prev_valid) begin
      if (p.bus_addr == IfA) glog = {glog, "I"};
      else glog = {glog, "M"};
      gcyc.push_back(cyc);
    end
    prev_valid = p.bus_valid;
  end

  // Memory slave: completes after s_wait extra cycles of bus_valid
  int          s_wait = 0;
  int          s_cnt = 0;
  bit          rnd_mode = 0;
  logic [63:0] s_data = 0;
  always @(negedge clk) begin
    if (rst || !p.bus_valid) begin
      s_cnt = 0;
      p.bus_ready = 1'b0;
      if (rnd_mode) s_wait = $urandom_range(0, 3);
    end else begin
      p.bus_ready = (s_cnt >= s_wait);
      s_cnt++;
    end
    p.bus_rdata = rnd_mode ? {$urandom, $urandom} : s_data;
  end

  // Requester agents: 0 = main drives, 1 = both always requesting,
  // 2 = random traffic, 3 = drop requests as they complete
  int mode = 0;
  always @(negedge clk) begin
    if (mode != 0 && !rst) begin
      if (p.if_ready || !p.if_req) begin
        case (mode)
          1: begin p.if_req = 1'b1; p.if_addr = IfA; end
          2: begin
            p.if_req  = ($urandom_range(0, 2) != 0);
            p.if_addr = {$urandom, $urandom} & ~64'h3;
          end
          default: p.if_req = 1'b0;
        endcase
      end
      if (p.mem_ready || !p.mem_req) begin
        case (mode)
          1: begin p.mem_req = 1'b1; p.mem_wen = 1'b0; p.mem_addr = MemA; end
          2: begin
            p.mem_req   = ($urandom_range(0, 2) != 0);
            p.mem_wen   = 1'($urandom);
            p.mem_addr  = {$urandom, $urandom};
            p.mem_wdata = {$urandom, $urandom};
            p.mem_wmask = {$urandom, $urandom};
          end
          default: p.mem_req = 1'b0;
        endcase
      end
    end
  end

  logic [63:0] f_addr, f_wdata, f_wmask;
  logic        f_wen;

  // One directed transaction; returns read data and req-to-ready latency
  task automatic txn(input bit is_mem, input bit wen, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [63:0] wmask,
                     output logic [63:0] rd, output int lat);
    @(negedge clk);
    if (is_mem) begin
      p.mem_req = 1'b1; p.mem_wen = wen; p.mem_addr = addr;
      p.mem_wdata = wdata; p.mem_wmask = wmask;
    end else begin
      p.if_req = 1'b1; p.if_addr = addr;
    end
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        f_addr = p.bus_addr; f_wen = p.bus_wen; f_wdata = p.bus_wdata; f_wmask = p.bus_wmask;
      end
      if (is_mem ? p.mem_ready : p.if_ready) break;
    end
    check("txn_ready", is_mem ? p.mem_ready : p.if_ready, 1'b1);
    rd = is_mem ? p.mem_rdata : {32'h0, p.if_rdata};
    if (is_mem) p.mem_req = 1'b0;
    else p.if_req = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_bus_valid"}, p.bus_valid, 0);
    check({tag, "_bus_wen"}, p.bus_wen, 0);
    check({tag, "_bus_addr"}, p.bus_addr, 0);
    check({tag, "_bus_wdata"}, p.bus_wdata, 0);
    check({tag, "_bus_wmask"}, p.bus_wmask, 0);
    check({tag, "_if_ready"}, p.if_ready, 0);
    check({tag, "_mem_ready"}, p.mem_ready, 0);
    check({tag, "_if_rdata"}, p.if_rdata, 0);
    check({tag, "_mem_rdata"}, p.mem_rdata, 0);
  endtask

  task automatic drain();
    mode = 3;
    for (int i = 0; i < 300 && (p.if_req || p.mem_req); i++) @(negedge clk);
    check("drain_reqs", {p.if_req, p.mem_req}, 0);
    mode = 0;
    repeat (3) @(negedge clk);
  endtask

  logic [63:0] rd;
  int          lat;

  initial begin
    p.if_req = 0; p.if_addr = 0;
    p.mem_req = 0; p.mem_wen = 0; p.mem_addr = 0; p.mem_wdata = 0; p.mem_wmask = 0;
    p.bus_ready = 0; p.bus_rdata = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    cmp_en = 1;

    // Lone IF, upper and lower lanes
    s_wait = 0;
    s_data = 64'h1234_5678_9ABC_DEF0;
    txn(0, 0, 64'h8000_0004, 0, 0, rd, lat);
    check("if_hi_lat", 64'(lat), 2);
    check("if_hi_rdata", rd, 64'h1234_5678);
    check("if_hi_bus_addr", f_addr, 64'h8000_0000);
    check("if_hi_bus_wen", f_wen, 0);
    txn(0, 0, 64'h8000_0000, 0, 0, rd, lat);
    check("if_lo_rdata", rd, 64'h9ABC_DEF0);

    // Store passes fields through, address aligned down
    s_data = 64'h0BAD_F00D_CAFE_0001;
    txn(1, 1, 64'h8000_1003, 64'hAB00_0000, 64'h0000_0000_FF00_0000, rd, lat);
    check("st_bus_addr", f_addr, 64'h8000_1000);
    check("st_bus_wen", f_wen, 1);
    check("st_bus_wdata", f_wdata, 64'hAB00_0000);
    check("st_bus_wmask", f_wmask, 64'h0000_0000_FF00_0000);
    check("st_lat", 64'(lat), 2);
    check("st_rdata", rd, 64'h0BAD_F00D_CAFE_0001);

    // Slave wait states
    s_wait = 5;
    txn(1, 0, 64'h8000_2008, 0, 0, rd, lat);
    check("wait_lat", 64'(lat), 7);
    s_wait = 0;

    // Starvation bound: both requesting continuously
    glog = "";
    gcyc.delete();
    mode = 1;
    for (int i = 0; i < 300 && glog.len() < 10; i++) @(negedge clk);
    n_vec++;
    if (glog != "MMMMIMMMMI") begin
      n_err++;
      $display("FAIL grant_order: got %s, expected MMMMIMMMMI", glog);
    end
    drain();

    // Simultaneous requests with an empty run count
    glog = "";
    gcyc.delete();
    @(negedge clk);
    p.if_req = 1'b1; p.if_addr = IfA;
    p.mem_req = 1'b1; p.mem_wen = 1'b0; p.mem_addr = MemA;
    for (int i = 0; i < 60 && (p.if_req || p.mem_req); i++) begin
      @(negedge clk);
      if (p.if_ready) p.if_req = 1'b0;
      if (p.mem_ready) p.mem_req = 1'b0;
    end
    n_vec++;
    if (glog != "MI") begin
      n_err++;
      $display("FAIL both_order: got %s, expected MI", glog);
    end
    check("both_spacing", (gcyc.size() >= 2) ? 64'(gcyc[1] - gcyc[0]) : 64'd0, 3);

    // Asynchronous reset in the middle of a MEM transaction
    s_wait = 1000;
    @(negedge clk);
    p.mem_req = 1'b1; p.mem_wen = 1'b1; p.mem_addr = 64'h3008;
    p.mem_wdata = 64'h55; p.mem_wmask = 64'hFF;
    @(negedge clk);
    check("mid_bus_valid", p.bus_valid, 1);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    p.mem_req = 1'b0;
    rst = 1'b0;
    s_wait = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stray_ready", {p.if_ready, p.mem_ready}, 0);
    end

    // Randomized traffic
    rnd_mode = 1;
    mode = 2;
    repeat (3000) @(negedge clk);
    drain();
    rnd_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single 64-bit memory port between the instruction-fetch requester (IF) and the load/store requester (MEM, driven from the decode outputs `mem_wen`/`mem_wdata`/`wmask` and the ALU address). It serialises one transaction at a time. MEM has priority, with a bounded-starvation guarantee for IF. It latches the granted request, runs the bus handshake, and returns a one-cycle ready pulse with registered read data to the granted requester.

## Interface
- MAX_MEM_RUN, 4, maximum consecutive MEM grants while IF is waiting (range 1..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  IF read request, held until if_ready
- if_addr  in  64  fetch byte address (4-byte aligned)
- if_ready  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched instruction
- mem_req  in  1  MEM request, held until mem_ready
- mem_wen  in  1  1 = store, 0 = load
- mem_addr  in  64  data byte address
- mem_wdata  in  64  store data, already lane-shifted
- mem_wmask  in  64  store bit mask, already lane-aligned
- mem_ready  out  1  one-cycle pulse: access complete, mem_rdata valid for loads
- mem_rdata  out  64  raw 64-bit doubleword read
- bus_valid  out  1  transaction valid, held until bus_ready
- bus_wen  out  1  write enable
- bus_addr  out  64  doubleword address, {addr[63:3],3'b000}
- bus_wdata  out  64  write data
- bus_wmask  out  64  write mask
- bus_ready  in  1  slave completes transaction in this cycle
- bus_rdata  in  64  read data, valid when bus_ready=1

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_MEM, DONE_IF, DONE_MEM.
- IDLE arbitration at each edge:
  - Only if_req: grant IF.
  - Only mem_req: grant MEM.
  - Both high: grant MEM, unless run_cnt == MAX_MEM_RUN, then grant IF.
  - Neither: stay in IDLE.
- On grant, register the requester's addr/wen/wdata/wmask into bus_* and go to BUSY_x.
  - IF grant forces wen=0, wdata=0, wmask=0.
  - Latched IF addr bit 2 is kept for lane select.
- BUSY_x:
  - bus_valid=1 and bus_* fields stable.
  - On bus_ready=1: register bus_rdata and go to DONE_x.
  - Otherwise wait; there is no timeout.
- DONE_IF:
  - if_ready=1.
  - if_rdata = latched addr[2] ? rdata[63:32] : rdata[31:0].
  - Next state IDLE.
- DONE_MEM: mem_ready=1, mem_rdata = rdata (64 bits, also updated for stores), next state IDLE.
- if_rdata/mem_rdata hold their last value until the next completion of the same requester.
- bus_valid=0 in IDLE/DONE; bus_addr/wen/wdata/wmask hold last latched values.
- run_cnt (4 bits):
  - Increments on a MEM grant taken while if_req=1, saturating at MAX_MEM_RUN.
  - Clears on any IF grant, or in IDLE whenever if_req=0.
- Requester rule: the req sampled in the cycle after its ready pulse (which is in IDLE) is treated as a new request.
  - A requester must drop or update req in that cycle.
  - Req must not be withdrawn while pending; if it is, behaviour is undefined.
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE; run_cnt=0.
  - bus_valid, bus_wen, bus_addr, bus_wdata, bus_wmask = 0.
  - if_ready, mem_ready = 0; if_rdata, mem_rdata = 0.
  - An in-flight bus transaction is abandoned; the slave shares the same rst.

## Timing
- Request sampled in IDLE at edge 0 → bus_valid=1 in cycle 1.
- bus_ready in cycle k → ready pulse in cycle k+1 → IDLE in cycle k+2.
- Minimum latency req-to-ready: 2 cycles (bus_ready in cycle 1). Minimum grant spacing: 3 cycles.
- Ready pulses are exactly 1 cycle. if_ready and mem_ready are never high together.
- bus_* outputs come straight from registers; no combinational path from bus_ready to bus_valid.

## Test plan
- Reset mid-BUSY_MEM (bus_valid=1, bus_ready held 0):
  - Assert rst asynchronously → bus_valid, all outputs and run_cnt go to 0 before the next edge.
  - After release, IDLE; no stray ready pulse.
- Lone IF:
  - if_addr=0x8000_0004, bus_rdata=0x1234_5678_9ABC_DEF0 with bus_ready in cycle 1 → bus_addr=0x8000_0000, bus_wen=0.
  - if_ready in cycle 2 with if_rdata=0x1234_5678.
  - Repeat with if_addr=0x8000_0000 → if_rdata=0x9ABC_DEF0.
- Store:
  - mem_wen=1, mem_addr=0x8000_1003, wmask=0x0000_0000_FF00_0000, wdata=0xAB00_0000 → bus_addr=0x8000_1000 with fields passed unchanged.
  - mem_ready exactly one cycle after bus_ready.
- Slave wait states:
  - bus_ready delayed 5 cycles → bus_valid and fields stable for 6 cycles.
  - Ready arrives at cycle 7.
- Priority and starvation with MAX_MEM_RUN=4:
  - if_req and mem_req both held high continuously → grant order MEM, MEM, MEM, MEM, IF, MEM…
  - run_cnt clears after the IF grant.
- Both requests raised in the same cycle with run_cnt=0 → MEM granted first, IF granted immediately after MEM's DONE/IDLE.
